// File: rtl/sram_like_slave.sv
// SRAM-like slave: one outstanding request, fixed LATENCY to data_ok, byte-lane writes.
// Define SRAM_SLAVE_STALL_EN to throttle data_addr_ok with an 8-bit LFSR.
module sram_like_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok
);

  localparam int          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LAT_LAST = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [31:0]             hold_q, hold_d;
  logic                    wr_q, wr_d;
  logic [31:0]             mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [3:0]              byte_mask;
  logic                    stall_ok;
  logic                    hs;
  logic                    unused_addr_bits;

  assign word_idx         = data_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{data_addr[31:ADDR_WIDTH+2], data_addr[1:0] & 2'b00};

`ifdef SRAM_SLAVE_STALL_EN
  logic [7:0] lfsr_q;

  // x^8+x^6+x^5+x^4+1, free-running from reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign stall_ok = lfsr_q[0];
`else
  assign stall_ok = 1'b1;
`endif

  // rst_n gating keeps the handshake (and memory writes) off while in reset
  assign data_addr_ok = rst_n && data_req && (state_q == S_IDLE) && stall_ok;
  assign hs           = data_addr_ok;
  assign data_data_ok = (state_q == S_RESP);
  assign data_rdata   = (data_data_ok && !wr_q) ? hold_q : 32'h0;

  always_comb begin
    byte_mask = 4'b1111;
    case (data_size)
      2'd0:    byte_mask = 4'b0001 << data_addr[1:0];
      2'd1:    byte_mask = data_addr[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          cnt_d   = 4'd0;
          wr_d    = data_wr;
          hold_d  = data_wr ? 32'h0 : mem_q[word_idx];
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == LAT_LAST) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      hold_q  <= 32'h0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      wr_q    <= wr_d;
    end
  end

  // Memory has no reset; contents survive rst_n
  always_ff @(posedge clk) begin
    if (hs && data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_mask[b]) begin
          mem_q[word_idx][8*b +: 8] <= data_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
